// File: rtl/xgriscv_mem_arb.sv
// Arbiter and sequencer for the unified xgriscv memory: grants one IF or D access at a time,
// counts out the fixed memory latency and routes the response back to the owner.
module xgriscv_mem_arb #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LAT     = 2,
   parameter int unsigned MAX_DSTREAK = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {StIdle, StWait} state_e;

   localparam logic [3:0] LatInit   = 4'(MEM_LAT - 1);
   localparam logic [3:0] StreakMax = 4'(MAX_DSTREAK);

   state_e     state_q, state_d;
   logic       owner_q, owner_d;  // 1 = D owns the access in flight
   logic [3:0] lat_q, lat_d;
   logic [3:0] streak_q, streak_d;
   logic       d_win, if_win;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         owner_q  <= 1'b0;
         lat_q    <= 4'd0;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         lat_q    <= lat_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      lat_d     = lat_q;
      streak_d  = streak_q;
      d_win     = 1'b0;
      if_win    = 1'b0;
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = 4'h0;

      case (state_q)
         StIdle: begin
            d_win  = d_req && !(if_req && (streak_q == StreakMax));
            if_win = if_req && !d_win;
            if (d_win) begin
               d_gnt     = 1'b1;
               mem_en    = 1'b1;
               mem_we    = d_we;
               mem_addr  = d_addr;
               mem_wdata = d_wdata;
               mem_be    = d_be;
               owner_d   = 1'b1;
               lat_d     = LatInit;
               state_d   = StWait;
               // D only wins with if_req pending while below the limit, so +1 saturates naturally
               streak_d  = if_req ? streak_q + 4'd1 : 4'd0;
            end else if (if_win) begin
               if_gnt    = 1'b1;
               mem_en    = 1'b1;
               mem_addr  = if_addr;
               mem_be    = 4'hF;
               owner_d   = 1'b0;
               lat_d     = LatInit;
               state_d   = StWait;
               streak_d  = 4'd0;
            end
         end
         StWait: begin
            if (lat_q != 4'd0) begin
               lat_d = lat_q - 4'd1;
            end else begin
               if (owner_q) begin
                  d_rvalid = 1'b1;
                  d_rdata  = mem_rdata;
               end else begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // The IDLE grant path is combinational, so it must be masked while reset is held
      if (!rstn) begin
         if_gnt    = 1'b0;
         if_rvalid = 1'b0;
         if_rdata  = '0;
         d_gnt     = 1'b0;
         d_rvalid  = 1'b0;
         d_rdata   = '0;
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         mem_be    = 4'h0;
      end
   end

endmodule

// File: tb/tb_xgriscv_mem_arb.sv
// Directed bench for xgriscv_mem_arb: one MEM_LAT=2 instance for the main sequence and one
// MEM_LAT=1 instance for back-to-back fetch timing.
module tb_xgriscv_mem_arb;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_be;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   logic        b_if_req;
   logic [31:0] b_if_addr, b_mem_rdata;
   logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
   logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_be;
   logic        zero1 = 1'b0;
   logic [31:0] zero32 = 32'h0;
   logic [3:0]  zero4 = 4'h0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   xgriscv_mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DSTREAK(3)) u_dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   xgriscv_mem_arb #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DSTREAK(3)) u_lat1 (
      .clk(clk), .rstn(rstn),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
      .if_rdata(b_if_rdata),
      .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32), .d_be(zero4),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_be(b_mem_be), .mem_rdata(b_mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      if_req = 1'b1; if_addr = 32'h1C;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h55; d_wdata = 32'h77; d_be = 4'hF;
      mem_rdata = 32'hFFFF_FFFF;
      b_if_req = 1'b0; b_if_addr = 32'h0; b_mem_rdata = 32'h0;

      // Reset: requests asserted but every output held at 0
      cyc(); settle();
      chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);

      // Idle, no request
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      cyc(); rstn = 1'b1; settle();
      chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
      chk("idle_mem_be", {28'b0, mem_be}, 32'd0);

      // Single fetch
      cyc(); if_req = 1'b1; if_addr = 32'h1C; mem_rdata = 32'h0; settle();
      chk("f_if_gnt", {31'b0, if_gnt}, 32'd1);
      chk("f_mem_en", {31'b0, mem_en}, 32'd1);
      chk("f_mem_addr", mem_addr, 32'h1C);
      chk("f_mem_be", {28'b0, mem_be}, 32'hF);
      chk("f_mem_we", {31'b0, mem_we}, 32'd0);
      chk("f_d_gnt", {31'b0, d_gnt}, 32'd0);
      cyc(); if_req = 1'b0; settle();
      chk("f_c1_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("f_c1_mem_en", {31'b0, mem_en}, 32'd0);
      cyc(); mem_rdata = 32'h00A0_0093; settle();
      chk("f_c2_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("f_c2_rdata", if_rdata, 32'h00A0_0093);
      chk("f_c2_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("f_c2_d_rdata", d_rdata, 32'h0);
      cyc(); settle();
      chk("f_c3_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("f_c3_rdata", if_rdata, 32'h0);

      // Store
      cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      d_be = 4'b0011; mem_rdata = 32'h0; settle();
      chk("s_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("s_mem_we", {31'b0, mem_we}, 32'd1);
      chk("s_mem_addr", mem_addr, 32'h100);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("s_mem_be", {28'b0, mem_be}, 32'h3);
      cyc(); d_req = 1'b0; d_we = 1'b0; settle();
      chk("s_c1_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      cyc(); mem_rdata = 32'h1234_5678; settle();
      chk("s_c2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
      chk("s_c2_d_rdata", d_rdata, 32'h1234_5678);
      chk("s_c2_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("s_c2_if_rdata", if_rdata, 32'h0);
      cyc(); settle();
      chk("s_c3_d_rvalid", {31'b0, d_rvalid}, 32'd0);

      // Simultaneous requests held high: D, D, D, IF, D
      cyc(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      d_be = 4'hF; settle();
      for (int g = 0; g < 5; g++) begin
         chk($sformatf("sim%0d_d_gnt", g), {31'b0, d_gnt}, (g == 3) ? 32'd0 : 32'd1);
         chk($sformatf("sim%0d_if_gnt", g), {31'b0, if_gnt}, (g == 3) ? 32'd1 : 32'd0);
         chk($sformatf("sim%0d_addr", g), mem_addr, (g == 3) ? 32'h40 : 32'h200);
         cyc(); settle();
         if (g == 4) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         chk($sformatf("sim%0d_wait_en", g), {31'b0, mem_en}, 32'd0);
         cyc(); mem_rdata = 32'hA000_0000 + g; settle();
         chk($sformatf("sim%0d_d_rv", g), {31'b0, d_rvalid}, (g == 3) ? 32'd0 : 32'd1);
         chk($sformatf("sim%0d_if_rv", g), {31'b0, if_rvalid}, (g == 3) ? 32'd1 : 32'd0);
         chk($sformatf("sim%0d_rdata", g), (g == 3) ? if_rdata : d_rdata, 32'hA000_0000 + g);
         cyc(); settle();
      end

      // Fairness reset: D-only traffic clears the streak, then D still wins a tie
      d_req = 1'b1; d_addr = 32'h300;
      for (int g = 0; g < 5; g++) begin
         settle();
         chk($sformatf("fr%0d_d_gnt", g), {31'b0, d_gnt}, 32'd1);
         cyc(); cyc(); cyc();
      end
      if_req = 1'b1; if_addr = 32'h80; settle();
      chk("fr_tie_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("fr_tie_if_gnt", {31'b0, if_gnt}, 32'd0);
      cyc(); d_req = 1'b0; if_req = 1'b0; cyc(); cyc(); settle();
      chk("fr_idle_en", {31'b0, mem_en}, 32'd0);

      // Reset mid-WAIT
      if_req = 1'b1; if_addr = 32'h24; mem_rdata = 32'hCAFE_F00D; settle();
      chk("rw_if_gnt", {31'b0, if_gnt}, 32'd1);
      cyc(); rstn = 1'b0; settle();
      chk("rw_rst_gnt", {31'b0, if_gnt}, 32'd0);
      chk("rw_rst_en", {31'b0, mem_en}, 32'd0);
      chk("rw_rst_addr", mem_addr, 32'h0);
      cyc(); rstn = 1'b1; settle();
      chk("rw_rel_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("rw_rel_gnt", {31'b0, if_gnt}, 32'd1);
      chk("rw_rel_addr", mem_addr, 32'h24);
      cyc(); if_req = 1'b0; settle();
      chk("rw_c1_rvalid", {31'b0, if_rvalid}, 32'd0);
      cyc(); settle();
      chk("rw_c2_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("rw_c2_rdata", if_rdata, 32'hCAFE_F00D);
      cyc();

      // MEM_LAT=1: fetches every 2 cycles, rvalid 1 cycle after each grant
      b_if_req = 1'b1; b_if_addr = 32'h400; b_mem_rdata = 32'h1111_0000; settle();
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("l1_%0d_gnt", g), {31'b0, b_if_gnt}, 32'd1);
         chk($sformatf("l1_%0d_en", g), {31'b0, b_mem_en}, 32'd1);
         chk($sformatf("l1_%0d_rv0", g), {31'b0, b_if_rvalid}, 32'd0);
         cyc(); b_mem_rdata = 32'h1111_0000 + g; settle();
         chk($sformatf("l1_%0d_rv", g), {31'b0, b_if_rvalid}, 32'd1);
         chk($sformatf("l1_%0d_rdata", g), b_if_rdata, 32'h1111_0000 + g);
         chk($sformatf("l1_%0d_gnt_w", g), {31'b0, b_if_gnt}, 32'd0);
         cyc(); settle();
      end
      b_if_req = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xgriscv_mem_arb.md
Name: xgriscv_mem_arb

Overview:
- Two-requester arbiter and sequencer for one shared single-port memory in the xgriscv core.
- The requesters are the instruction-fetch port (IF) and the load/store data port (D).
- Used when the core moves from separate imem/dmem to a unified memory with fixed multi-cycle latency.
- Grants one access at a time, counts out the memory latency, and routes the response to the owner. D has priority, with an anti-starvation limit for IF.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata. Legal range is 1..15.
- MAX_DSTREAK, 3, maximum consecutive D grants while if_req is pending. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  4  byte enables
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid / write ack
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe (one cycle)
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset state:
  - State IDLE, owner=IF, lat_cnt=0, streak=0.
  - All outputs are 0 during reset and in IDLE with no request.
- States: IDLE, WAIT.
- IDLE, combinational grant:
  - Winner is D if d_req and not (if_req and streak==MAX_DSTREAK). Otherwise IF if if_req.
  - Winner's gnt=1 and mem_en=1.
  - mem_addr, mem_we, mem_wdata and mem_be are taken from the winner. For IF: mem_we=0, mem_be=4'hF, mem_wdata=0.
  - On the clock edge: owner<=winner, lat_cnt<=MEM_LAT-1, go to WAIT.
  - No request: stay in IDLE, mem_* = 0.
- WAIT:
  - No grants and mem_en=0.
  - If lat_cnt!=0: decrement.
  - If lat_cnt==0: owner's rvalid=1 for exactly this cycle, owner's rdata=mem_rdata, then next state is IDLE.
- Timing:
  - Grant in cycle T gives rvalid in cycle T+MEM_LAT.
  - The next grant is no earlier than T+MEM_LAT+1. Throughput is one access per MEM_LAT+1 cycles.
- Writes:
  - Follow the same sequence.
  - d_rvalid pulses as the write ack; d_rdata equals mem_rdata and is don't-care to the consumer.
- Outputs to non-owner: rvalid and rdata are always 0.
- Streak counter, updated on each grant edge:
  - D grant with if_req=1: streak<=min(streak+1, MAX_DSTREAK).
  - D grant with if_req=0: streak<=0.
  - IF grant: streak<=0.
- Requester protocol:
  - req, addr, wdata, we and be must be held stable until the matching gnt.
  - req may drop or change in the cycle after gnt.
  - req changes during WAIT are ignored and sampled again only in IDLE.
- Simultaneous if_req and d_req: resolved by the grant rule above, never both granted.
- Reset mid-operation: asynchronous return to IDLE. Any pending rvalid is dropped and never issued, streak=0.

Test Plan:
- Single fetch, MEM_LAT=2:
  - Stimulus: if_req=1, if_addr=0x1C at cycle 0, mem_rdata=0x00A00093 from cycle 2.
  - Response: if_gnt=1 and mem_en=1 with mem_addr=0x1C at cycle 0; if_rvalid=1 with if_rdata=0x00A00093 at cycle 2 only; IDLE at cycle 3.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Response: mem_we=1 with matching mem_* in the grant cycle; d_rvalid pulse 2 cycles later; if_rvalid stays 0.
- Simultaneous requests, both held high:
  - Response: grants run D, D, D, IF, D, ... (MAX_DSTREAK=3), each separated by 3 cycles.
- Fairness reset:
  - Stimulus: D-only traffic for 5 grants, then if_req rises together with d_req.
  - Response: D is granted, since streak was 0.
- MEM_LAT=1:
  - Response: back-to-back fetches are granted every 2 cycles; rvalid appears 1 cycle after each grant.
- Reset mid-WAIT:
  - Stimulus: rstn=0 one cycle after a grant.
  - Response: all outputs 0 immediately; no rvalid after release; the next request is granted in its first IDLE cycle.
